// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/execute pair: instruction width, field layout, opcodes, fetch FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cpu_pkg;

  localparam int INSTR_W = 12;

  // Instruction field positions: opcode | dest | src1 | src2
  localparam int OPC_MSB  = 11;
  localparam int OPC_LSB  = 9;
  localparam int DST_MSB  = 8;
  localparam int DST_LSB  = 6;
  localparam int SRC1_MSB = 5;
  localparam int SRC1_LSB = 3;
  localparam int SRC2_MSB = 2;
  localparam int SRC2_LSB = 0;

  // Opcodes shared with the ALU
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_LDI = 3'd7;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_ISSUE = 2'd2,
    FS_DONE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_rom.sv
// Program store: one write port, one registered read port with read enable.
// Latency: read data appears one cycle after re; rdata holds while re is low.
// Backpressure: none; caller gates we/re.
// Ports: clk, rst_n (clears only the read register), we/waddr/wdata write port,
//        re/raddr read request, rdata registered read data.
module instr_rom #(
  parameter int INSTR_W = 12,
  parameter int PC_W    = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [PC_W-1:0]    waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic               re,
  input  logic [PC_W-1:0]    raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [2**PC_W];

  // Storage is deliberately not reset so a program survives a reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register doubles as the presented instruction, so it resets to 0
  // and only updates when a fetch is requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: holds the program and issues prog_len words in order to the execute stage.
// Latency: start in cycle N -> instr_valid in N+2; one instruction per 2 cycles at best.
// Backpressure: instr/pc hold while instr_valid && !instr_ready; start and prog_we ignored while busy.
// Ports: clk, rst_n; prog_we/prog_addr/prog_wdata program load; prog_len, start run control;
//        instr/instr_valid/instr_ready issue handshake; pc current address; busy, done status.
module instr_fetch_unit #(
  parameter int INSTR_W = cpu_pkg::INSTR_W,
  parameter int PC_W    = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_wdata,
  input  logic [PC_W:0]      prog_len,
  input  logic               start,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               done
);

  import cpu_pkg::*;

  localparam logic [PC_W:0] MEM_DEPTH = {1'b1, {PC_W{1'b0}}};

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W:0]   len_q, len_d;
  logic [PC_W:0]   pc_inc;
  logic            mem_we;
  logic            rd_en;

  // One bit wider than pc so the last-word test at pc = 2**PC_W-1 cannot overflow.
  assign pc_inc = {1'b0, pc_q} + (PC_W + 1)'(1);

  instr_rom #(
    .INSTR_W (INSTR_W),
    .PC_W    (PC_W)
  ) u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_wdata),
    .re    (rd_en),
    .raddr (pc_q),
    .rdata (instr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    mem_we  = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      FS_IDLE, FS_DONE: begin
        // Write and start may coincide; the write lands before the fetch of
        // address 0 in the following cycle.
        mem_we = prog_we;
        if (start) begin
          len_d   = (prog_len > MEM_DEPTH) ? MEM_DEPTH : prog_len;
          pc_d    = '0;
          state_d = (prog_len == '0) ? FS_DONE : FS_FETCH;
        end
      end
      FS_FETCH: begin
        rd_en   = 1'b1;
        state_d = FS_ISSUE;
      end
      FS_ISSUE: begin
        if (instr_ready) begin
          if (pc_inc == len_q) begin
            state_d = FS_DONE;
          end else begin
            pc_d    = pc_q + PC_W'(1);
            state_d = FS_FETCH;
          end
        end
      end
      default: state_d = FS_IDLE;
    endcase
  end

  assign instr_valid = (state_q == FS_ISSUE);
  assign busy        = (state_q == FS_FETCH) || (state_q == FS_ISSUE);
  assign done        = (state_q == FS_DONE);
  assign pc          = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed program scenarios plus randomized runs against a
// program-image reference that predicts the ordered list of issued words per run.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_instr_fetch_unit;

  localparam int INSTR_W = 12;
  localparam int PC_W    = 6;
  localparam int DEPTH   = 64;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               prog_we = 1'b0;
  logic [PC_W-1:0]    prog_addr = '0;
  logic [INSTR_W-1:0] prog_wdata = '0;
  logic [PC_W:0]      prog_len = '0;
  logic               start = 1'b0;
  logic               instr_ready = 1'b0;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic [PC_W-1:0]    pc;
  logic               busy;
  logic               done;

  int checks   = 0;
  int failures = 0;

  logic [INSTR_W-1:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .INSTR_W (INSTR_W),
    .PC_W    (PC_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_wdata  (prog_wdata),
    .prog_len    (prog_len),
    .start       (start),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .busy        (busy),
    .done        (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called right after a falling edge; returns right after the next one.
  task automatic load(input int addr, input logic [INSTR_W-1:0] data);
    prog_we    = 1'b1;
    prog_addr  = addr[PC_W-1:0];
    prog_wdata = data;
    ref_mem[addr] = data;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_instr"}, 32'(instr), 32'h0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'h0);
    chk({tag, "_pc"}, 32'(pc), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low for 5 cycles on word 1.
  // abort_at >= 0: assert reset while word abort_at is presented and return.
  task automatic run(input int len, input int mode, input bit wr0,
                     input logic [INSTR_W-1:0] wr0_data, input int abort_at);
    logic [INSTR_W-1:0] exp_q[$];
    int  eff, idx, k, budget, stall;
    bit  seen_valid;
    eff = (len > DEPTH) ? DEPTH : len;
    if (wr0) begin
      prog_we    = 1'b1;
      prog_addr  = '0;
      prog_wdata = wr0_data;
      ref_mem[0] = wr0_data;
    end
    for (int i = 0; i < eff; i++) exp_q.push_back(ref_mem[i]);
    start    = 1'b1;
    prog_len = len[PC_W:0];
    @(negedge clk);
    start       = 1'b0;
    prog_we     = 1'b0;
    instr_ready = 1'b0;
    idx = 0; k = 1; stall = 0; seen_valid = 1'b0;
    budget = 10 * eff + 50;
    if (eff == 0) begin
      chk("zero_len_done", 32'(done), 32'h1);
    end else begin
      chk("fetch_busy", 32'(busy), 32'h1);
      chk("fetch_no_valid", 32'(instr_valid), 32'h0);
    end
    while (!done && k < budget) begin
      if (instr_valid) begin
        if (!seen_valid) begin
          chk("start_latency", 32'(k), 32'd2);
          seen_valid = 1'b1;
        end
        if (idx < eff) begin
          chk("instr", 32'(instr), 32'(exp_q[idx]));
          chk("pc", 32'(pc), 32'(idx));
        end else begin
          chk("extra_issue", 32'(idx), 32'(eff));
        end
        if (idx == abort_at) begin
          start       = 1'b0;
          prog_we     = 1'b0;
          instr_ready = 1'b0;
          rst_n       = 1'b0;
          #1;
          check_reset_outputs("async_rst");
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
      end
      case (mode)
        0: instr_ready = 1'b1;
        1: instr_ready = ($urandom_range(0, 1) == 1);
        default: begin
          if (instr_valid && idx == 1 && stall < 5) begin
            instr_ready = 1'b0;
            stall++;
          end else begin
            instr_ready = 1'b1;
          end
        end
      endcase
      // Disturb the run: restarts and writes while busy must have no effect.
      start    = busy && ($urandom_range(0, 3) == 0);
      prog_len = 7'($urandom_range(0, 127));
      prog_we  = busy && ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) begin
        prog_addr  = 6'd1;
        prog_wdata = 12'hFFF;
      end else begin
        prog_addr  = 6'($urandom);
        prog_wdata = 12'($urandom);
      end
      if (instr_valid && instr_ready) idx++;
      @(negedge clk);
      k++;
    end
    start       = 1'b0;
    prog_we     = 1'b0;
    instr_ready = 1'b0;
    chk("run_done", 32'(done), 32'h1);
    chk("issue_count", 32'(idx), 32'(eff));
    chk("final_pc", 32'(pc), 32'((eff > 0) ? eff - 1 : 0));
    chk("final_valid", 32'(instr_valid), 32'h0);
    chk("final_busy", 32'(busy), 32'h0);
    if (mode == 0 && eff > 0) chk("throughput", 32'(k), 32'(2 * eff + 1));
  endtask

  initial begin
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle");

    // Basic three-word program
    load(0, 12'h0D1);
    load(1, 12'h2CA);
    load(2, 12'h453);
    run(3, 0, 1'b0, '0, -1);
    // Stall while presenting word 1
    run(3, 2, 1'b0, '0, -1);
    // Zero length
    run(0, 0, 1'b0, '0, -1);
    // Reset in the middle of word 1, then rerun from IDLE with memory intact
    run(3, 0, 1'b0, '0, 1);
    check_reset_outputs("post_rst");
    run(3, 0, 1'b0, '0, -1);
    // Random ready with busy writes (including FFF to address 1), then verify contents
    run(3, 1, 1'b0, '0, -1);
    run(3, 0, 1'b0, '0, -1);
    // Start and write of address 0 in the same cycle
    run(2, 0, 1'b1, 12'hABC, -1);

    // Whole memory, then an over-length run that must clamp
    for (int a = 0; a < DEPTH; a++) load(a, 12'(a));
    run(64, 0, 1'b0, '0, -1);
    run(100, 1, 1'b0, '0, -1);

    // Randomized programs and lengths
    for (int it = 0; it < 20; it++) begin
      for (int w = 0; w < 8; w++) load($urandom_range(0, DEPTH - 1), 12'($urandom));
      run($urandom_range(0, 127), 1, ($urandom_range(0, 1) == 1), 12'($urandom), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
